// File: rtl/out_chk_pkg.sv
// Shared types and constants for the counter-pattern sequence checker.
`ifndef WIDTH
`define WIDTH 8
`endif

package out_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int unsigned SEQ_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/out_seq_checker.sv
// Locks onto an incrementing counter stream and counts words that break it.
module out_seq_checker
    import out_chk_pkg::*;
#(
    parameter int unsigned WIDTH    = `WIDTH,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    chk_state_t           state, state_next;
    logic [WIDTH-1:0]     exp, exp_next;
    logic [SEQ_CNT_W-1:0] run, run_next;
    logic [SEQ_CNT_W-1:0] bad, bad_next;
    logic                 err_c;
    logic                 word_c;
    logic                 match_c;

    assign match_c = (in_data == exp);

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state     <= HUNT;
            exp       <= '0;
            run       <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            exp       <= exp_next;
            run       <= run_next;
            bad       <= bad_next;
            locked    <= (state_next == LOCKED);
            err_pulse <= err_c;
        end
    end

    always_comb begin
        state_next = state;
        exp_next   = exp;
        run_next   = run;
        bad_next   = bad;
        err_c      = 1'b0;
        word_c     = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    exp_next   = in_data + WIDTH'(1);
                    run_next   = SEQ_CNT_W'(1);
                    state_next = VERIFY;
                end
                VERIFY: begin
                    if (match_c) begin
                        exp_next = exp + WIDTH'(1);
                        run_next = run + SEQ_CNT_W'(1);
                        if (run_next == SEQ_CNT_W'(LOCK_CNT)) begin
                            state_next = LOCKED;
                            bad_next   = '0;
                        end
                    end else begin
                        // Mismatch before lock just restarts the sequence from this word
                        exp_next = in_data + WIDTH'(1);
                        run_next = SEQ_CNT_W'(1);
                    end
                end
                LOCKED: begin
                    word_c   = 1'b1;
                    exp_next = exp + WIDTH'(1);
                    if (match_c) begin
                        bad_next = '0;
                    end else begin
                        err_c    = 1'b1;
                        bad_next = bad + SEQ_CNT_W'(1);
                        if (bad_next == SEQ_CNT_W'(LOSS_CNT)) begin
                            state_next = HUNT;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (ref_clk),
        .rst (rst),
        .inc (err_c),
        .clr (clr),
        .q   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk (ref_clk),
        .rst (rst),
        .inc (word_c),
        .clr (clr),
        .q   (word_cnt)
    );

endmodule

// File: tb/tb_out_seq_checker.sv
// Directed bench for out_seq_checker with hand-computed expectations.
module tb_out_seq_checker;

    logic        ref_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;

    logic        sat_inc = 1'b0;
    logic        sat_clr = 1'b0;
    logic [2:0]  sat_q;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 ref_clk = ~ref_clk;

    out_seq_checker #(
        .WIDTH    (8),
        .LOCK_CNT (4),
        .LOSS_CNT (4),
        .CNT_W    (16)
    ) u_dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt)
    );

    sat_counter #(.W(3)) u_sat (
        .clk (ref_clk),
        .rst (rst),
        .inc (sat_inc),
        .clr (sat_clr),
        .q   (sat_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Apply one cycle of input; outputs are looked at 1 time unit after the edge.
    task automatic step(input logic [7:0] d, input logic v);
        in_data  = d;
        in_valid = v;
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic lk, input logic ep,
                             input logic [15:0] ec, input logic [15:0] wc);
        chk({tag, ".locked"},    32'(locked),    32'(lk));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
        chk({tag, ".word_cnt"},  32'(word_cnt),  32'(wc));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        rst = 1'b0;
        step(8'h00, 1'b0);
        chk_state("reset", 1'b0, 1'b0, 16'd0, 16'd0);

        // Lock on 0x10..0x13
        step(8'h10, 1'b1);
        step(8'h11, 1'b1);
        step(8'h12, 1'b1);
        chk_state("lock_pre", 1'b0, 1'b0, 16'd0, 16'd0);
        step(8'h13, 1'b1);
        chk_state("lock", 1'b1, 1'b0, 16'd0, 16'd0);

        // Advance to 0x20, then a single error
        for (int i = 8'h14; i <= 8'h1F; i++) step(8'(i), 1'b1);
        chk_state("run_1f", 1'b1, 1'b0, 16'd0, 16'd12);
        step(8'h20, 1'b1);
        chk_state("single_20", 1'b1, 1'b0, 16'd0, 16'd13);
        step(8'h55, 1'b1);
        chk_state("single_55", 1'b1, 1'b1, 16'd1, 16'd14);
        step(8'h22, 1'b1);
        chk_state("single_22", 1'b1, 1'b0, 16'd1, 16'd15);

        // Run up to 0xFE and wrap through zero
        for (int i = 8'h23; i <= 8'hFD; i++) step(8'(i), 1'b1);
        chk_state("run_fd", 1'b1, 1'b0, 16'd1, 16'd234);
        step(8'hFE, 1'b1);
        chk("wrap_fe.err_pulse", 32'(err_pulse), 32'd0);
        step(8'hFF, 1'b1);
        chk("wrap_ff.err_pulse", 32'(err_pulse), 32'd0);
        step(8'h00, 1'b1);
        chk("wrap_00.err_pulse", 32'(err_pulse), 32'd0);
        step(8'h01, 1'b1);
        chk_state("wrap_01", 1'b1, 1'b0, 16'd1, 16'd238);

        // Clear coincident with an error: pulse fires, counts go to zero
        clr = 1'b1;
        step(8'h99, 1'b1);
        clr = 1'b0;
        chk_state("clr_err", 1'b1, 1'b1, 16'd0, 16'd0);
        step(8'h03, 1'b1);
        chk_state("clr_after", 1'b1, 1'b0, 16'd0, 16'd1);

        // Four consecutive errors drop lock
        step(8'hAA, 1'b1);
        chk_state("loss_1", 1'b1, 1'b1, 16'd1, 16'd2);
        step(8'hAA, 1'b1);
        step(8'hAA, 1'b1);
        chk_state("loss_3", 1'b1, 1'b1, 16'd3, 16'd4);
        step(8'hAA, 1'b1);
        chk_state("loss_4", 1'b0, 1'b1, 16'd4, 16'd5);

        // Relock on 0x30..0x33
        step(8'h30, 1'b1);
        step(8'h31, 1'b1);
        step(8'h32, 1'b1);
        chk_state("relock_pre", 1'b0, 1'b0, 16'd4, 16'd5);
        step(8'h33, 1'b1);
        chk_state("relock", 1'b1, 1'b0, 16'd4, 16'd5);

        // Reset while locked overrides clr and a mismatching valid word
        rst = 1'b1;
        clr = 1'b1;
        step(8'h77, 1'b1);
        chk_state("rst_locked", 1'b0, 1'b0, 16'd0, 16'd0);
        rst = 1'b0;
        clr = 1'b0;
        step(8'h00, 1'b0);
        chk_state("rst_idle", 1'b0, 1'b0, 16'd0, 16'd0);

        // Gapped stream with a re-seed in VERIFY
        step(8'h05, 1'b1);
        step(8'hEE, 1'b0);
        step(8'h06, 1'b1);
        step(8'hEE, 1'b0);
        step(8'h40, 1'b1);
        step(8'hEE, 1'b0);
        step(8'h41, 1'b1);
        step(8'hEE, 1'b0);
        step(8'h42, 1'b1);
        chk_state("gap_42", 1'b0, 1'b0, 16'd0, 16'd0);
        step(8'hEE, 1'b0);
        step(8'h43, 1'b1);
        chk_state("gap_43", 1'b1, 1'b0, 16'd0, 16'd0);
        step(8'hEE, 1'b0);
        chk_state("gap_idle", 1'b1, 1'b0, 16'd0, 16'd0);

        // Saturation of a narrow counter instance
        sat_inc = 1'b1;
        for (int i = 0; i < 9; i++) step(8'h00, 1'b0);
        chk("sat_hold", 32'(sat_q), 32'd7);
        sat_clr = 1'b1;
        step(8'h00, 1'b0);
        chk("sat_clr_prio", 32'(sat_q), 32'd0);
        sat_clr = 1'b0;
        step(8'h00, 1'b0);
        chk("sat_after_clr", 32'(sat_q), 32'd1);
        sat_inc = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
